// File: rtl/cache_pkg.sv
// Shared types, geometry helpers and address field extraction for the
// set-associative cache controller.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FILL   = 2'd2,
        ST_WRMEM  = 2'd3
    } state_e;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_WORDS  = 8;
    localparam int DEF_SETS   = 64;
    localparam int DEF_WAYS   = 2;

    // Widest address the field extractor handles.
    localparam int FIELD_W = 32;

    function automatic int calc_off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int calc_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    // Byte-in-word bit 0 is not part of any field.
    function automatic int calc_tag_w(input int addr_w, input int words, input int sets);
        return addr_w - 1 - $clog2(words) - $clog2(sets);
    endfunction

    localparam int OFF_W = calc_off_w(DEF_WORDS);
    localparam int IDX_W = calc_idx_w(DEF_SETS);
    localparam int TAG_W = calc_tag_w(DEF_ADDR_W, DEF_WORDS, DEF_SETS);

    function automatic logic [FIELD_W-1:0] addr_field(input logic [FIELD_W-1:0] addr,
                                                      input int lsb,
                                                      input int width);
        logic [FIELD_W-1:0] mask;
        mask = (FIELD_W'(1) << width) - FIELD_W'(1);
        return (addr >> lsb) & mask;
    endfunction

endpackage

// File: rtl/cache_lru_set.sv
// Age-based LRU for one set: next ages after an access and the oldest way.
module cache_lru_set
    import cache_pkg::*;
#(
    parameter int WAYS  = DEF_WAYS,
    parameter int AGE_W = 1,
    parameter int WAY_W = 1
) (
    input  logic [WAYS-1:0][AGE_W-1:0] i_ages,
    input  logic [WAY_W-1:0]           i_acc_way,
    output logic [WAYS-1:0][AGE_W-1:0] o_ages_next,
    output logic [WAY_W-1:0]           o_victim
);

    logic [AGE_W-1:0] w_acc_age;

    // Accessed way becomes youngest; ways younger than it age by one.
    always_comb begin
        w_acc_age   = i_ages[i_acc_way];
        o_ages_next = i_ages;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == i_acc_way) begin
                o_ages_next[w] = AGE_W'(0);
            end else if (i_ages[w] < w_acc_age) begin
                o_ages_next[w] = i_ages[w] + AGE_W'(1);
            end else begin
                o_ages_next[w] = i_ages[w];
            end
        end
    end

    // Ages form a permutation, so exactly one way holds the maximum.
    always_comb begin
        o_victim = WAY_W'(0);
        for (int w = 0; w < WAYS; w++) begin
            if (i_ages[w] == AGE_W'(WAYS - 1)) begin
                o_victim = WAY_W'(w);
            end else begin
                o_victim = o_victim;
            end
        end
    end

endmodule

// File: rtl/cache_ctrl_assoc.sv
// N-way set-associative write-through, write-allocate cache controller.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module cache_ctrl_assoc
    import cache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int WORDS  = DEF_WORDS,
    parameter int SETS   = DEF_SETS,
    parameter int WAYS   = DEF_WAYS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    input  logic              i_req_write,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_stall,
    output logic              o_rvalid,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_mem_en,
    output logic              o_mem_wr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_valid
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       o_hit_cnt,
    output logic [15:0]       o_miss_cnt
`endif
);

    localparam int L_OFF_W = calc_off_w(WORDS);
    localparam int L_IDX_W = calc_idx_w(SETS);
    localparam int L_TAG_W = calc_tag_w(ADDR_W, WORDS, SETS);
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int AGE_W   = WAY_W;

    state_e                    r_state, w_state_nx;
    logic [ADDR_W-1:0]         r_addr;
    logic                      r_write;
    logic [DATA_W-1:0]         r_wdata;
    logic [L_OFF_W:0]          r_iss_cnt;
    logic [L_OFF_W-1:0]        r_rcv_cnt;
    logic [WAY_W-1:0]          r_victim;
    logic                      r_refill;

    logic [WAYS-1:0]           r_valid [SETS];
    logic [L_TAG_W-1:0]        r_tag   [SETS][WAYS];
    logic [WAYS-1:0][AGE_W-1:0] r_age  [SETS];
    logic [DATA_W-1:0]         r_data  [SETS][WAYS][WORDS];

    logic [L_OFF_W-1:0]        w_off;
    logic [L_IDX_W-1:0]        w_idx;
    logic [L_TAG_W-1:0]        w_tag;
    logic [WAYS-1:0]           w_hit_vec;
    logic                      w_hit;
    logic [WAY_W-1:0]          w_hit_way;
    logic                      w_inv_found;
    logic [WAY_W-1:0]          w_inv_way;
    logic [WAY_W-1:0]          w_lru_victim;
    logic [WAY_W-1:0]          w_victim_sel;
    logic [WAYS-1:0][AGE_W-1:0] w_age_nx;
    logic [DATA_W-1:0]         w_hit_data;
    logic                      w_fill_last;
    logic                      w_dwr_en;
    logic [WAY_W-1:0]          w_dwr_way;
    logic [L_OFF_W-1:0]        w_dwr_off;
    logic [DATA_W-1:0]         w_dwr_data;

    assign w_off = L_OFF_W'(addr_field(FIELD_W'(r_addr), 1, L_OFF_W));
    assign w_idx = L_IDX_W'(addr_field(FIELD_W'(r_addr), 1 + L_OFF_W, L_IDX_W));
    assign w_tag = L_TAG_W'(addr_field(FIELD_W'(r_addr), 1 + L_OFF_W + L_IDX_W, L_TAG_W));

    // Tag compare across the set, plus lowest-numbered hit and invalid way.
    always_comb begin
        w_hit_vec   = '0;
        w_hit_way   = WAY_W'(0);
        w_inv_found = 1'b0;
        w_inv_way   = WAY_W'(0);
        for (int w = 0; w < WAYS; w++) begin
            w_hit_vec[w] = r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_hit_vec[w]) begin
                w_hit_way = WAY_W'(w);
            end else begin
                w_hit_way = w_hit_way;
            end
            if (!r_valid[w_idx][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(w);
            end else begin
                w_inv_found = w_inv_found;
                w_inv_way   = w_inv_way;
            end
        end
    end

    assign w_hit        = |w_hit_vec;
    assign w_victim_sel = w_inv_found ? w_inv_way : w_lru_victim;
    assign w_hit_data   = r_data[w_idx][w_hit_way][w_off];
    assign w_fill_last  = (r_state == ST_FILL) && i_mem_valid &&
                          (r_rcv_cnt == L_OFF_W'(WORDS - 1));

    cache_lru_set #(
        .WAYS  (WAYS),
        .AGE_W (AGE_W),
        .WAY_W (WAY_W)
    ) u_lru (
        .i_ages      (r_age[w_idx]),
        .i_acc_way   (w_hit_way),
        .o_ages_next (w_age_nx),
        .o_victim    (w_lru_victim)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state, pipeline/memory outputs and the data-array write port.
    always_comb begin
        w_state_nx  = r_state;
        o_stall     = 1'b0;
        o_rvalid    = 1'b0;
        o_rdata     = '0;
        o_mem_en    = 1'b0;
        o_mem_wr    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        w_dwr_en    = 1'b0;
        w_dwr_way   = w_hit_way;
        w_dwr_off   = w_off;
        w_dwr_data  = r_wdata;
        case (r_state)
            ST_IDLE: begin
                o_stall = i_req_valid;
                if (i_req_valid) begin
                    w_state_nx = ST_LOOKUP;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (w_hit && !r_write) begin
                    o_rvalid   = 1'b1;
                    o_rdata    = w_hit_data;
                    w_state_nx = ST_IDLE;
                end else if (w_hit) begin
                    o_stall    = 1'b1;
                    w_dwr_en   = 1'b1;
                    w_state_nx = ST_WRMEM;
                end else begin
                    o_stall    = 1'b1;
                    w_state_nx = ST_FILL;
                end
            end
            ST_FILL: begin
                o_stall = 1'b1;
                if (!r_iss_cnt[L_OFF_W]) begin
                    o_mem_en   = 1'b1;
                    o_mem_addr = {r_addr[ADDR_W-1:L_OFF_W+1], r_iss_cnt[L_OFF_W-1:0], 1'b0};
                end else begin
                    o_mem_en   = 1'b0;
                end
                if (i_mem_valid) begin
                    w_dwr_en   = 1'b1;
                    w_dwr_way  = r_victim;
                    w_dwr_off  = r_rcv_cnt;
                    w_dwr_data = i_mem_rdata;
                end else begin
                    w_dwr_en   = 1'b0;
                end
                if (w_fill_last) begin
                    w_state_nx = ST_LOOKUP;
                end else begin
                    w_state_nx = ST_FILL;
                end
            end
            ST_WRMEM: begin
                o_stall     = 1'b1;
                o_mem_en    = 1'b1;
                o_mem_wr    = 1'b1;
                o_mem_addr  = {r_addr[ADDR_W-1:1], 1'b0};
                o_mem_wdata = r_wdata;
                w_state_nx  = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Request capture and fill bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_iss_cnt <= '0;
            r_rcv_cnt <= '0;
            r_victim  <= WAY_W'(0);
            r_refill  <= 1'b0;
        end else if (r_state == ST_IDLE && i_req_valid) begin
            r_addr   <= i_req_addr;
            r_write  <= i_req_write;
            r_wdata  <= i_req_wdata;
            r_refill <= 1'b0;
        end else if (r_state == ST_LOOKUP && !w_hit) begin
            r_victim  <= w_victim_sel;
            r_iss_cnt <= '0;
            r_rcv_cnt <= '0;
        end else if (r_state == ST_FILL) begin
            if (!r_iss_cnt[L_OFF_W]) begin
                r_iss_cnt <= r_iss_cnt + (L_OFF_W + 1)'(1);
            end
            if (i_mem_valid) begin
                r_rcv_cnt <= r_rcv_cnt + L_OFF_W'(1);
            end
            if (w_fill_last) begin
                r_refill <= 1'b1;
            end
        end
    end

    // Valid bits and LRU ages; the victim stays invalid until its fill completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_age[s][w]   <= AGE_W'(w);
                end
            end
        end else begin
            if (r_state == ST_LOOKUP && w_hit) begin
                r_age[w_idx] <= w_age_nx;
            end
            if (r_state == ST_LOOKUP && !w_hit) begin
                r_valid[w_idx][w_victim_sel] <= 1'b0;
            end
            if (w_fill_last) begin
                r_valid[w_idx][r_victim] <= 1'b1;
            end
        end
    end

    // Tag array write on allocation.
    always_ff @(posedge clk) begin
        if (r_state == ST_LOOKUP && !w_hit) begin
            r_tag[w_idx][w_victim_sel] <= w_tag;
        end
    end

    // Data array single write port: store hit or fill beat.
    always_ff @(posedge clk) begin
        if (w_dwr_en) begin
            r_data[w_idx][w_dwr_way][w_dwr_off] <= w_dwr_data;
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    // Saturating counters; the re-lookup after a fill is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= 16'd0;
            r_miss_cnt <= 16'd0;
        end else if (r_state == ST_LOOKUP && !r_refill) begin
            if (w_hit) begin
                if (r_hit_cnt != 16'hFFFF) begin
                    r_hit_cnt <= r_hit_cnt + 16'd1;
                end
            end else begin
                if (r_miss_cnt != 16'hFFFF) begin
                    r_miss_cnt <= r_miss_cnt + 16'd1;
                end
            end
        end
    end

    assign o_hit_cnt  = r_hit_cnt;
    assign o_miss_cnt = r_miss_cnt;
`endif

endmodule

// File: doc/cache_ctrl_assoc.md
# cache_ctrl_assoc

Parametrised N-way set-associative, write-through, write-allocate cache controller sitting between the pipeline memory stage and the multicycle main memory. It owns its tag/valid/LRU metadata and data storage, stalls the pipeline for every access it cannot finish in the lookup cycle, and fills missing blocks with a pipelined burst of word reads. It generalises the fixed 2-way, 8-word-block controller to configurable ways, sets, block size and address/data width.

## Interface
- ADDR_W, 16, byte address width
- DATA_W, 16, word width; bit 0 of the address is ignored, so accesses are word-aligned
- WORDS, 8, words per block (power of 2)
- SETS, 64, sets (power of 2)
- WAYS, 2, associativity (1, 2 or 4)
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  access request; held with all fields stable while stall is high
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data
- stall  out  1  pipeline stall
- rvalid  out  1  one-cycle pulse: rdata is valid
- rdata  out  DATA_W  load data
- mem_en  out  1  memory request strobe
- mem_wr  out  1  memory write qualifier
- mem_addr  out  ADDR_W  memory word address (bit 0 = 0)
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_valid  in  1  read data returned, in issue order, a fixed but unknown number of cycles after its mem_en

## Operation
- Address split: offset = [log2(WORDS):1], index = next log2(SETS) bits, tag = remaining upper bits.
- States: IDLE, LOOKUP, FILL, WRMEM.
- IDLE: on req_valid, register the request and go to LOOKUP. Requests arriving in any other state are ignored because the requester holds them.
- LOOKUP: compare the tag against all ways of the set.
  - Load hit: drive rdata, pulse rvalid, update LRU, go to IDLE.
  - Store hit: write the word into the cache, update LRU, go to WRMEM.
  - Miss: choose the victim as the lowest-numbered invalid way, otherwise the LRU way. Clear its valid bit, write the new tag, go to FILL.
- FILL: issue WORDS reads, one per cycle, at offsets 0..WORDS-1 (mem_en=1, mem_wr=0). A separate receive counter writes each mem_valid beat into the victim way. Issue and receive overlap.
  - After the last beat, set valid and go to LOOKUP, which then hits.
- WRMEM: one cycle with mem_en=1, mem_wr=1 and the store word. Then go to IDLE. Memory accepts writes in a single cycle.
- LRU: per-set age counters of log2(WAYS) bits. On an access, the accessed way becomes 0; ways younger than it increment. The victim is the way at the maximum age. WAYS=1 has no LRU state.
- stall = req_valid in IDLE, or state != IDLE and not (LOOKUP with a load hit).
- A mem_valid seen outside FILL is ignored.

## Timing
- Reset (async, rst_n=0): state IDLE; all valid bits 0; LRU ages set to way index; stall=0, rvalid=0, rdata=0, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- Reset during FILL abandons the fill. Late mem_valid beats after reset are ignored.
- Load hit: request in cycle 0, rvalid in cycle 1, stall deasserts in cycle 1.
- Store hit: stall in cycles 0–2. WRMEM is cycle 2.
- Load miss: rvalid arrives WORDS + L + 2 cycles after the request, where L is the mem_en-to-mem_valid latency.
- Back-to-back: a new request is accepted in the cycle after the controller returns to IDLE.

## Configuration
- CACHE_STATS_EN defined: adds two 16-bit saturating output counters, hit_cnt and miss_cnt.
  - Each increments once per LOOKUP on its first evaluation; the post-fill re-lookup is not counted.
  - Both clear on reset.
- CACHE_STATS_EN undefined: the counters and their ports are absent.

## Structure
- A shared package cache_pkg holds:
  - the state enum;
  - derived widths: OFF_W, IDX_W, TAG_W;
  - an address field-extraction function.
- One sub-module, cache_lru_set: the age update and victim select for one set, combinational over WAYS age fields.
- Metadata and data storage are inferred arrays inside the top module.

## Test plan
- Load 0x0010 after reset:
  - 8 reads issued at 0x0010–0x001E;
  - memory returns 0xA000+i;
  - rvalid with rdata=0xA000.
- Repeat load of 0x0014: hit, rvalid in cycle 1, rdata=0xA002, no mem_en.
- Store 0x1234 to 0x0014 (hit):
  - stall for 3 cycles;
  - mem_wr at 0x0014 with 0x1234;
  - a later load of 0x0014 returns 0x1234.
- WAYS=2, three tags mapping to index 0:
  - A, B, A, then C evicts B;
  - a reload of B misses, and A still hits.
- Assert rst_n low mid-FILL: all outputs return to reset values immediately; a following load of the same address misses.
- With CACHE_STATS_EN, after the above sequence: hit_cnt and miss_cnt match the scoreboard counts.
